// File: rtl/requant_ctrl.sv
// requant_ctrl
//   Frame-based requantization controller. On an accepted start it latches a
//   right-shift amount and a frame length, then streams Len unsigned
//   accumulator values through a one-stage output register. Each value is
//   shifted right and narrowed to the activation width. The controller uses
//   a valid/ready handshake on both sides and pulses Done_Out for one cycle
//   at the end of every frame.
//
//   Build option: define REQUANT_CTRL_SAT_EN to saturate values that do not
//   fit in DATAOUT_WIDTH bits to all-ones. Without it, the low bits are kept.
//
//   Ports
//     RequantCtrl_CLOCK_50      clock, rising edge
//     RequantCtrl_RESET_InHigh  asynchronous active-high reset
//     RequantCtrl_Start_In      frame start (honoured only in IDLE)
//     RequantCtrl_Shift_InBUS   right-shift amount, latched on start
//     RequantCtrl_Len_InBUS     elements per frame, latched on start
//     RequantCtrl_InBUS         unsigned accumulator data
//     RequantCtrl_InValid       input data valid
//     RequantCtrl_InReady       controller accepts input
//     RequantCtrl_OutBUS        requantized activation
//     RequantCtrl_OutValid      output data valid
//     RequantCtrl_OutReady      downstream accepts output
//     RequantCtrl_Busy_Out      high while not IDLE
//     RequantCtrl_Done_Out      one-cycle end-of-frame pulse
module requant_ctrl #(
    parameter int DATAIN_WIDTH  = 14,
    parameter int DATAOUT_WIDTH = 8,
    parameter int LEN_WIDTH     = 10
) (
    input  logic                     RequantCtrl_CLOCK_50,
    input  logic                     RequantCtrl_RESET_InHigh,
    input  logic                     RequantCtrl_Start_In,
    input  logic [2:0]               RequantCtrl_Shift_InBUS,
    input  logic [LEN_WIDTH-1:0]     RequantCtrl_Len_InBUS,
    input  logic [DATAIN_WIDTH-1:0]  RequantCtrl_InBUS,
    input  logic                     RequantCtrl_InValid,
    output logic                     RequantCtrl_InReady,
    output logic [DATAOUT_WIDTH-1:0] RequantCtrl_OutBUS,
    output logic                     RequantCtrl_OutValid,
    input  logic                     RequantCtrl_OutReady,
    output logic                     RequantCtrl_Busy_Out,
    output logic                     RequantCtrl_Done_Out
);

    // Largest shift that can still use every output bit.
    localparam logic [2:0] MAX_SHIFT = 3'(DATAIN_WIDTH - DATAOUT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [2:0]               shift_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     count;
    logic [DATAOUT_WIDTH-1:0] out_bus;
    logic                     out_valid;
    logic                     in_ready;
    logic                     start_accept;
    logic                     in_xfer;
    logic [DATAOUT_WIDTH-1:0] result;

    assign start_accept = (state == IDLE) && RequantCtrl_Start_In;
    assign in_xfer      = RequantCtrl_InValid && in_ready;

`ifdef REQUANT_CTRL_SAT_EN
    logic [DATAIN_WIDTH-1:0] shifted;
    assign shifted = RequantCtrl_InBUS >> shift_q;
    assign result  = (|shifted[DATAIN_WIDTH-1:DATAOUT_WIDTH]) ? '1
                                                              : shifted[DATAOUT_WIDTH-1:0];
`else
    assign result  = DATAOUT_WIDTH'(RequantCtrl_InBUS >> shift_q);
`endif

    // State register
    always_ff @(posedge RequantCtrl_CLOCK_50 or posedge RequantCtrl_RESET_InHigh) begin
        if (RequantCtrl_RESET_InHigh) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and state-derived outputs
    always_comb begin
        next_state           = state;
        in_ready             = 1'b0;
        RequantCtrl_Busy_Out = 1'b1;
        RequantCtrl_Done_Out = 1'b0;
        case (state)
            IDLE: begin
                RequantCtrl_Busy_Out = 1'b0;
                if (RequantCtrl_Start_In) begin
                    next_state = (RequantCtrl_Len_InBUS == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = (count < len_q) && (!out_valid || RequantCtrl_OutReady);
                // Leave only once the last result has left the output register.
                if ((count == len_q) && (!out_valid || RequantCtrl_OutReady)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                RequantCtrl_Done_Out = 1'b1;
                next_state           = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Frame parameters and element counter
    always_ff @(posedge RequantCtrl_CLOCK_50 or posedge RequantCtrl_RESET_InHigh) begin
        if (RequantCtrl_RESET_InHigh) begin
            shift_q <= '0;
            len_q   <= '0;
            count   <= '0;
        end else if (start_accept) begin
            shift_q <= (RequantCtrl_Shift_InBUS > MAX_SHIFT) ? MAX_SHIFT
                                                             : RequantCtrl_Shift_InBUS;
            len_q   <= RequantCtrl_Len_InBUS;
            count   <= '0;
        end else if (in_xfer) begin
            count   <= count + LEN_WIDTH'(1);
        end
    end

    // Output register: loads on an input transfer, holds under backpressure
    always_ff @(posedge RequantCtrl_CLOCK_50 or posedge RequantCtrl_RESET_InHigh) begin
        if (RequantCtrl_RESET_InHigh) begin
            out_bus   <= '0;
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            out_bus   <= result;
            out_valid <= 1'b1;
        end else if (out_valid && RequantCtrl_OutReady) begin
            out_valid <= 1'b0;
        end
    end

    assign RequantCtrl_InReady  = in_ready;
    assign RequantCtrl_OutBUS   = out_bus;
    assign RequantCtrl_OutValid = out_valid;

endmodule

// File: tb/tb_requant_ctrl.sv
// tb_requant_ctrl
//   Directed bench for requant_ctrl: single-element frames from a vector
//   table, followed by hand-written multi-cycle sequences (streaming frame,
//   start during RUN, backpressure, empty frame, mid-frame reset).
module tb_requant_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  shift;
    logic [9:0]  len;
    logic [13:0] in_bus;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_bus;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    requant_ctrl #(
        .DATAIN_WIDTH (14),
        .DATAOUT_WIDTH(8),
        .LEN_WIDTH    (10)
    ) dut (
        .RequantCtrl_CLOCK_50    (clk),
        .RequantCtrl_RESET_InHigh(rst),
        .RequantCtrl_Start_In    (start),
        .RequantCtrl_Shift_InBUS (shift),
        .RequantCtrl_Len_InBUS   (len),
        .RequantCtrl_InBUS       (in_bus),
        .RequantCtrl_InValid     (in_valid),
        .RequantCtrl_InReady     (in_ready),
        .RequantCtrl_OutBUS      (out_bus),
        .RequantCtrl_OutValid    (out_valid),
        .RequantCtrl_OutReady    (out_ready),
        .RequantCtrl_Busy_Out    (busy),
        .RequantCtrl_Done_Out    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  shift;
        logic [13:0] data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-element frame; entered and left 1 time unit after a rising edge in IDLE.
    task automatic run_frame1(input logic [2:0] sh, input logic [13:0] data, input logic [7:0] exp);
        start     = 1'b1;
        shift     = sh;
        len       = 10'd1;
        out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("f1_busy_run", busy, 1);
        in_valid = 1'b1;
        in_bus   = data;
        #1;
        check("f1_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("f1_out_valid", out_valid, 1);
        check("f1_out_bus", out_bus, exp);
        tick();
        check("f1_done", done, 1);
        check("f1_out_valid_clr", out_valid, 0);
        tick();
        check("f1_done_clr", done, 0);
        check("f1_busy_idle", busy, 0);
    endtask

    initial begin
        // shift, data, expected (shift 7 is clamped to 6)
        vecs[0] = '{3'd0, 14'h00AB, 8'hAB};
        vecs[1] = '{3'd6, 14'h3FFF, 8'hFF};
        vecs[2] = '{3'd7, 14'h1FC0, 8'h7F};
        vecs[3] = '{3'd3, 14'h07F8, 8'hFF};
        vecs[4] = '{3'd4, 14'h0AB0, 8'hAB};
        vecs[5] = '{3'd1, 14'h0002, 8'h01};
        vecs[6] = '{3'd5, 14'h0000, 8'h00};
        vecs[7] = '{3'd6, 14'h0040, 8'h01};
`ifdef REQUANT_CTRL_SAT_EN
        vecs[8] = '{3'd2, 14'h0400, 8'hFF};
        vecs[9] = '{3'd1, 14'h0300, 8'hFF};
`else
        vecs[8] = '{3'd2, 14'h0400, 8'h00};
        vecs[9] = '{3'd1, 14'h0300, 8'h80};
`endif

        rst       = 1'b1;
        start     = 1'b0;
        shift     = '0;
        len       = '0;
        in_bus    = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        check("rst_out_bus", out_bus, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_frame1(vecs[i].shift, vecs[i].data, vecs[i].exp);
        end

        // Streaming frame, Shift=6 Len=3, with a second start during RUN
        // (Shift=0, Len=5) that must be ignored.
        start     = 1'b1;
        shift     = 3'd6;
        len       = 10'd3;
        out_ready = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_bus   = 14'h3FFF;
        tick();
        check("s_out0", out_bus, 8'hFF);
        check("s_valid0", out_valid, 1);
        in_bus = 14'h0040;
        start  = 1'b1;
        shift  = 3'd0;
        len    = 10'd5;
        tick();
        start = 1'b0;
        check("s_out1", out_bus, 8'h01);
        in_bus = 14'h1234;
        tick();
        check("s_out2", out_bus, 8'h48);
        check("s_valid2", out_valid, 1);
        check("s_no_done_yet", done, 0);
        in_valid = 1'b0;
        #1;
        check("s_in_ready_full", in_ready, 0);
        tick();
        check("s_done", done, 1);
        check("s_valid_clr", out_valid, 0);
        check("s_busy_done", busy, 1);
        tick();
        check("s_done_clr", done, 0);
        check("s_idle", busy, 0);

        // Backpressure: Len=4, OutReady low for 3 cycles after first output
        start     = 1'b1;
        shift     = 3'd0;
        len       = 10'd4;
        out_ready = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_bus   = 14'h0011;
        tick();
        check("bp_out0", out_bus, 8'h11);
        out_ready = 1'b0;
        in_bus    = 14'h0022;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready_low", in_ready, 0);
            check("bp_hold_bus", out_bus, 8'h11);
            check("bp_hold_valid", out_valid, 1);
            tick();
        end
        check("bp_hold_after", out_bus, 8'h11);
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_resume", in_ready, 1);
        tick();
        check("bp_out1", out_bus, 8'h22);
        in_bus = 14'h0033;
        tick();
        check("bp_out2", out_bus, 8'h33);
        in_bus = 14'h0044;
        tick();
        check("bp_out3", out_bus, 8'h44);
        check("bp_valid3", out_valid, 1);
        in_valid = 1'b0;
        tick();
        check("bp_done", done, 1);
        tick();
        check("bp_idle", busy, 0);

        // Empty frame
        start = 1'b1;
        len   = 10'd0;
        tick();
        start = 1'b0;
        check("z_busy", busy, 1);
        check("z_done", done, 1);
        check("z_valid", out_valid, 0);
        check("z_in_ready", in_ready, 0);
        tick();
        check("z_busy_clr", busy, 0);
        check("z_done_clr", done, 0);
        check("z_valid_clr", out_valid, 0);

        // Reset after 2 of 5 elements
        start = 1'b1;
        shift = 3'd0;
        len   = 10'd5;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_bus   = 14'h0005;
        tick();
        in_bus = 14'h0006;
        tick();
        check("r_out1", out_bus, 8'h06);
        in_bus = 14'h0007;
        #2;
        rst = 1'b1;
        #1;
        check("r_out_bus", out_bus, 0);
        check("r_out_valid", out_valid, 0);
        check("r_busy", busy, 0);
        check("r_in_ready", in_ready, 0);
        check("r_done", done, 0);
        in_valid = 1'b0;
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("r_no_done", done, 0);
            check("r_no_valid", out_valid, 0);
        end
        run_frame1(3'd4, 14'h0AB0, 8'hAB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/requant_ctrl.md
REQUANT_CTRL -- requirements
Module: requant_ctrl

Interface
REQ-001 Parameter DATAIN_WIDTH, default 14: accumulator input width.
REQ-002 Parameter DATAOUT_WIDTH, default 8: activation output width.
REQ-003 Parameter LEN_WIDTH, default 10: width of the frame-length field.
REQ-004 Port RequantCtrl_CLOCK_50, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port RequantCtrl_RESET_InHigh, input, 1: asynchronous, active-high reset.
REQ-006 Port RequantCtrl_Start_In, input, 1: frame start pulse.
REQ-007 Port RequantCtrl_Shift_InBUS, input, 3: right-shift amount, sampled on accepted start.
REQ-008 Port RequantCtrl_Len_InBUS, input, LEN_WIDTH: elements per frame, sampled on accepted start.
REQ-009 Port RequantCtrl_InBUS, input, DATAIN_WIDTH: unsigned accumulator data.
REQ-010 Port RequantCtrl_InValid, input, 1: input data valid.
REQ-011 Port RequantCtrl_InReady, output, 1: controller accepts input.
REQ-012 Port RequantCtrl_OutBUS, output, DATAOUT_WIDTH: requantized activation.
REQ-013 Port RequantCtrl_OutValid, output, 1: output data valid.
REQ-014 Port RequantCtrl_OutReady, input, 1: downstream accepts output.
REQ-015 Port RequantCtrl_Busy_Out, output, 1: high while state is not IDLE.
REQ-016 Port RequantCtrl_Done_Out, output, 1: one-cycle end-of-frame pulse.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE.
REQ-018 In IDLE, a Start_In high SHALL latch Shift and Len and go to RUN; if Len==0 it SHALL go to DONE instead.
REQ-019 Start_In SHALL be ignored outside IDLE.
REQ-020 A latched Shift greater than DATAIN_WIDTH-DATAOUT_WIDTH (6) SHALL be clamped to 6.
REQ-021 InReady SHALL equal (state==RUN) AND (accepted count < Len) AND (!OutValid OR OutReady).
REQ-022 An input transfer SHALL occur when InValid and InReady are both high.
REQ-023 The output register SHALL load on the same edge as the transfer, giving 1-cycle latency; it SHALL hold when OutValid is high and OutReady is low.
REQ-024 OutValid SHALL clear after an output transfer if no new input transfer occurs on that edge.
REQ-025 The result value SHALL be shifted = InBUS >> Shift, computed unsigned at DATAIN_WIDTH bits.
REQ-026 The accepted-element counter SHALL increment on each input transfer and clear on entry to RUN.
REQ-027 RUN SHALL go to DONE when count==Len and OutValid is low, or when OutValid is being consumed that cycle.
REQ-028 DONE SHALL last exactly one cycle with Done_Out high, then return to IDLE.
REQ-029 Simultaneous input and output transfers SHALL sustain one element per cycle.

Reset
REQ-030 Reset SHALL asynchronously force IDLE, count=0, OutBUS=0, OutValid=0, Done_Out=0, Busy_Out=0, InReady=0 and latched Shift/Len=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame; the pending output SHALL be discarded and no Done_Out SHALL be issued.

Configuration
REQ-032 The macro REQUANT_CTRL_SAT_EN SHALL control overflow handling of the shifted value.
REQ-033 With REQUANT_CTRL_SAT_EN defined, a shifted value greater than 2^DATAOUT_WIDTH-1 SHALL output 255.
REQ-034 Without REQUANT_CTRL_SAT_EN, the output SHALL be the low DATAOUT_WIDTH bits of the shifted value; behaviour at Shift=6 SHALL be identical in both builds.

Verification
REQ-035 Start, Shift=6, Len=3; inputs 0x3FFF, 0x0040, 0x1234 with OutReady=1 -> outputs 0xFF, 0x01, 0x48 at 1-cycle latency; Done_Out pulses 1 cycle after the last output.
REQ-036 Shift=2, input 0x0400, SAT build -> output 0xFF; non-SAT build -> output 0x00.
REQ-037 Len=4 with OutReady low for 3 cycles after the first output -> OutBUS held, InReady=0, no data loss; 4 outputs total.
REQ-038 Len=0 -> Busy_Out high for 1 cycle, Done_Out pulse, no OutValid.
REQ-039 Start pulsed again during RUN with a different Shift -> ignored; the frame completes with the original Shift.
REQ-040 Reset asserted after 2 of 5 elements -> all outputs 0 immediately, no Done_Out; a new Start afterwards runs a normal frame.
